// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: an output register plus one skid slot.
// Both the forward path (valid/last/data) and the backward path (ready) leave the block straight from flops.
module axis_skid_buffer #(
    parameter int AXIS_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    sresetn,
    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                    axis_o_tready,
    output logic                    axis_o_tvalid,
    output logic                    axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0] axis_o_tdata
);
    localparam int W = AXIS_BYTES * 8;

    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t         state, state_nxt;
    logic           ready_q, valid_q, last_q, skid_last;
    logic [W-1:0]   data_q, skid_data;
    logic           in_acc, out_xfer;
    logic           ld_out_in, ld_out_skid, ld_skid;

    assign in_acc   = axis_i_tvalid & ready_q;
    assign out_xfer = valid_q & axis_o_tready;

    // State register; ready/valid are registered copies of the next state's flags.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != FULL);
            valid_q <= (state_nxt != EMPTY);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (in_acc) state_nxt = BUSY;
            BUSY: begin
                if (in_acc && !out_xfer)      state_nxt = FULL;
                else if (!in_acc && out_xfer) state_nxt = EMPTY;
            end
            FULL:    if (out_xfer) state_nxt = BUSY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        ld_out_in   = 1'b0;
        ld_out_skid = 1'b0;
        ld_skid     = 1'b0;
        case (state)
            EMPTY: ld_out_in = in_acc;
            BUSY: begin
                ld_out_in = in_acc & out_xfer;
                ld_skid   = in_acc & ~out_xfer;
            end
            FULL:  ld_out_skid = out_xfer;
            default: ;
        endcase
    end

    // Payload registers carry no reset: they are only observed while valid is high.
    always_ff @(posedge clk) begin
        if (ld_out_in) begin
            data_q <= axis_i_tdata;
            last_q <= axis_i_tlast;
        end else if (ld_out_skid) begin
            data_q <= skid_data;
            last_q <= skid_last;
        end
        if (ld_skid) begin
            skid_data <= axis_i_tdata;
            skid_last <= axis_i_tlast;
        end
    end

    assign axis_i_tready = ready_q;
    assign axis_o_tvalid = valid_q;
    assign axis_o_tlast  = last_q;
    assign axis_o_tdata  = data_q;
endmodule

// File: tb/tb_axis_skid_buffer.sv
// Directed and random-stall checks of axis_skid_buffer (4-byte payload).
module tb_axis_skid_buffer;
    localparam int B = 4;
    localparam int W = B * 8;

    logic         clk = 1'b0;
    logic         sresetn;
    logic         i_tready, i_tvalid, i_tlast;
    logic [W-1:0] i_tdata;
    logic         o_tready, o_tvalid, o_tlast;
    logic [W-1:0] o_tdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_skid_buffer #(.AXIS_BYTES(B)) dut (
        .clk(clk), .sresetn(sresetn),
        .axis_i_tready(i_tready), .axis_i_tvalid(i_tvalid),
        .axis_i_tlast(i_tlast), .axis_i_tdata(i_tdata),
        .axis_o_tready(o_tready), .axis_o_tvalid(o_tvalid),
        .axis_o_tlast(o_tlast), .axis_o_tdata(o_tdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic l);
        i_tvalid = v;
        i_tdata  = d;
        i_tlast  = l;
    endtask

    logic [W:0]   sb[$];
    logic [W:0]   front;
    logic         acc, xfer, stalled, pl;
    logic [W-1:0] pd;
    int           sent, cyc;

    initial begin
        sresetn = 1'b0;
        o_tready = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Reset and release
        step(); step();
        chk("rst_tready", 64'(i_tready), 64'd0);
        chk("rst_tvalid", 64'(o_tvalid), 64'd0);
        sresetn = 1'b1;
        #2;
        chk("rel_tready_before_edge", 64'(i_tready), 64'd0);
        step();
        chk("rel_tready", 64'(i_tready), 64'd1);
        chk("rel_tvalid", 64'(o_tvalid), 64'd0);

        // Back-to-back streaming with a 1-cycle latency
        o_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), i == 8);
            step();
            chk($sformatf("stream_beat%0d", i), {o_tvalid, o_tlast, o_tdata},
                {1'b1, (i == 8), W'(i)});
            chk($sformatf("stream_ready%0d", i), 64'(i_tready), 64'd1);
        end
        drive(1'b0, '0, 1'b0);
        step();
        chk("stream_drained", 64'(o_tvalid), 64'd0);

        // Skid fill under backpressure
        o_tready = 1'b0;
        drive(1'b1, W'('hA1), 1'b0);
        step();
        chk("skid_a1_out", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b0, W'('hA1)});
        chk("skid_ready_busy", 64'(i_tready), 64'd1);
        drive(1'b1, W'('hA2), 1'b0);
        step();
        chk("skid_full_hold", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b0, W'('hA1)});
        chk("skid_ready_full", 64'(i_tready), 64'd0);
        drive(1'b1, W'('hA3), 1'b1);
        step(); step();
        chk("skid_a3_waits", {o_tvalid, o_tdata}, {1'b1, W'('hA1)});
        chk("skid_ready_still0", 64'(i_tready), 64'd0);
        o_tready = 1'b1;
        step();
        chk("skid_a2_out", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b0, W'('hA2)});
        chk("skid_ready_rise", 64'(i_tready), 64'd1);
        step();
        chk("skid_a3_out", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b1, W'('hA3)});
        drive(1'b0, '0, 1'b0);
        step();
        chk("skid_drained", 64'(o_tvalid), 64'd0);

        // Reset while FULL drops both held beats
        o_tready = 1'b0;
        drive(1'b1, W'('h11), 1'b0);
        step();
        drive(1'b1, W'('h22), 1'b1);
        step();
        chk("mr_full", 64'(i_tready), 64'd0);
        drive(1'b0, '0, 1'b0);
        sresetn = 1'b0;
        step();
        chk("mr_tvalid", 64'(o_tvalid), 64'd0);
        chk("mr_tready", 64'(i_tready), 64'd0);
        sresetn = 1'b1;
        o_tready = 1'b1;
        step();
        chk("mr_ready_back", 64'(i_tready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mr_no_stale%0d", i), 64'(o_tvalid), 64'd0);
            step();
        end
        drive(1'b1, W'('h33), 1'b1);
        step();
        chk("mr_fresh", {o_tvalid, o_tlast, o_tdata}, {1'b1, 1'b1, W'('h33)});
        drive(1'b0, '0, 1'b0);
        step();

        // Random valid/ready with a scoreboard
        sent = 0;
        cyc = 0;
        stalled = 1'b0;
        pl = 1'b0;
        pd = '0;
        while (sent < 10000 && cyc < 60000) begin
            if (stalled)
                chk("rand_stable", {o_tvalid, o_tlast, o_tdata}, {1'b1, pl, pd});
            drive(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)));
            o_tready = 1'($urandom_range(1));
            #1;
            acc  = i_tvalid & i_tready;
            xfer = o_tvalid & o_tready;
            if (xfer) begin
                if (sb.size() == 0) begin
                    chk("rand_spurious", 64'(o_tvalid), 64'd0);
                end else begin
                    front = sb.pop_front();
                    chk("rand_beat", {o_tlast, o_tdata}, front);
                end
            end
            if (acc) begin
                sb.push_back({i_tlast, i_tdata});
                sent++;
            end
            stalled = o_tvalid & ~o_tready;
            pl = o_tlast;
            pd = o_tdata;
            step();
            cyc++;
        end
        chk("rand_sent_all", 64'(sent), 64'd10000);

        // Drain whatever is still held
        drive(1'b0, '0, 1'b0);
        o_tready = 1'b1;
        cyc = 0;
        while (o_tvalid && cyc < 10) begin
            #1;
            if (sb.size() == 0) begin
                chk("drain_spurious", 64'(o_tvalid), 64'd0);
            end else begin
                front = sb.pop_front();
                chk("drain_beat", {o_tlast, o_tdata}, front);
            end
            step();
            cyc++;
        end
        chk("drain_idle", 64'(o_tvalid), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
